// File: rtl/instruction_fetch.sv
// rtl/instruction_fetch.sv - fetch stage: PC, combinational imem address, IF/ID register
// Optional halt-on-HALT_WORD behaviour is enabled by defining IF_HALT_EN.
module instruction_fetch #(
    parameter int                    ADDR_WIDTH = 10,
    parameter int                    DATA_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0,
    parameter logic [DATA_WIDTH-1:0] NOP_WORD   = '0,
    parameter logic [DATA_WIDTH-1:0] HALT_WORD  = '1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  stall,
    input  logic                  redirect,
    input  logic [ADDR_WIDTH-1:0] redirect_pc,
    output logic [ADDR_WIDTH-1:0] imem_address,
    input  logic [DATA_WIDTH-1:0] imem_instruction,
    output logic [DATA_WIDTH-1:0] if_id_instruction,
    output logic [ADDR_WIDTH-1:0] if_id_pc,
    output logic [ADDR_WIDTH-1:0] if_id_pc_next,
    output logic                  if_id_valid,
    output logic                  halted
);

    localparam logic [ADDR_WIDTH-1:0] PC_ONE = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

    logic [ADDR_WIDTH-1:0] pc_q, pc_d;
    logic [DATA_WIDTH-1:0] instr_q, instr_d;
    logic [ADDR_WIDTH-1:0] id_pc_q, id_pc_d;
    logic [ADDR_WIDTH-1:0] id_pc_next_q, id_pc_next_d;
    logic                  valid_q, valid_d;
    logic [ADDR_WIDTH-1:0] pc_plus1;

    // frozen: HALTED state; halt_hit: the halt word is being taken this edge
    logic frozen;
    logic halt_hit;

`ifdef IF_HALT_EN
    typedef enum logic {
        S_RUN    = 1'b0,
        S_HALTED = 1'b1
    } state_t;

    state_t state_q, state_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_RUN;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (state_q == S_RUN && !redirect && !stall && imem_instruction == HALT_WORD) begin
            state_d = S_HALTED;
        end
    end

    always_comb begin
        frozen   = (state_q == S_HALTED);
        halt_hit = (state_q == S_RUN) && (state_d == S_HALTED);
        halted   = frozen;
    end
`else
    assign frozen   = 1'b0;
    assign halt_hit = 1'b0;
    assign halted   = 1'b0;
`endif

    assign pc_plus1 = pc_q + PC_ONE;

    always_comb begin
        pc_d         = pc_q;
        instr_d      = instr_q;
        id_pc_d      = id_pc_q;
        id_pc_next_d = id_pc_next_q;
        valid_d      = valid_q;
        if (frozen) begin
            pc_d = pc_q;
        end else if (redirect) begin
            // squash the slot but keep its pc fields for debug visibility
            pc_d    = redirect_pc;
            instr_d = NOP_WORD;
            valid_d = 1'b0;
        end else if (stall) begin
            pc_d = pc_q;
        end else if (halt_hit) begin
            instr_d = NOP_WORD;
            valid_d = 1'b0;
        end else begin
            pc_d         = pc_plus1;
            instr_d      = imem_instruction;
            id_pc_d      = pc_q;
            id_pc_next_d = pc_plus1;
            valid_d      = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q         <= RESET_PC;
            instr_q      <= NOP_WORD;
            id_pc_q      <= '0;
            id_pc_next_q <= '0;
            valid_q      <= 1'b0;
        end else begin
            pc_q         <= pc_d;
            instr_q      <= instr_d;
            id_pc_q      <= id_pc_d;
            id_pc_next_q <= id_pc_next_d;
            valid_q      <= valid_d;
        end
    end

    assign imem_address      = pc_q;
    assign if_id_instruction = instr_q;
    assign if_id_pc          = id_pc_q;
    assign if_id_pc_next     = id_pc_next_q;
    assign if_id_valid       = valid_q;

endmodule

// File: tb/tb_instruction_fetch.sv
// tb/tb_instruction_fetch.sv - directed scoreboard bench for instruction_fetch
// Halt scenario expectations follow IF_HALT_EN when defined.
module tb_instruction_fetch;

    logic        clk = 1'b0;
    logic        reset;
    logic        stall;
    logic        redirect;
    logic [9:0]  redirect_pc;
    logic [9:0]  imem_address;
    logic [31:0] imem_instruction;
    logic [31:0] if_id_instruction;
    logic [9:0]  if_id_pc;
    logic [9:0]  if_id_pc_next;
    logic        if_id_valid;
    logic        halted;

    logic [31:0] mem [0:1023];
    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [31:0] instr;
        logic [9:0]  pc;
        logic [9:0]  pcn;
        logic        valid;
        logic        halted;
        logic [9:0]  addr;
    } exp_t;

    exp_t sb[$];

    always #5 clk = ~clk;

    assign imem_instruction = mem[imem_address];

    instruction_fetch dut (
        .clk              (clk),
        .reset            (reset),
        .stall            (stall),
        .redirect         (redirect),
        .redirect_pc      (redirect_pc),
        .imem_address     (imem_address),
        .imem_instruction (imem_instruction),
        .if_id_instruction(if_id_instruction),
        .if_id_pc         (if_id_pc),
        .if_id_pc_next    (if_id_pc_next),
        .if_id_valid      (if_id_valid),
        .halted           (halted)
    );

    function automatic exp_t ex(input logic [31:0] instr, input logic [9:0] pc,
                                input logic [9:0] pcn, input logic valid,
                                input logic hlt, input logic [9:0] addr);
        exp_t e;
        e.instr  = instr;
        e.pc     = pc;
        e.pcn    = pcn;
        e.valid  = valid;
        e.halted = hlt;
        e.addr   = addr;
        return e;
    endfunction

    function automatic logic [31:0] word(input int a);
        return 32'h0010_0001 + a;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    // Drive one cycle of stimulus, queue its expected IF/ID state, compare after the edge
    task automatic step(input string tag, input logic rst, input logic s, input logic r,
                        input logic [9:0] rp, input exp_t e);
        exp_t got;
        reset       = rst;
        stall       = s;
        redirect    = r;
        redirect_pc = rp;
        sb.push_back(e);
        @(posedge clk);
        #1;
        got = sb.pop_front();
        chk({tag, ".instr"},  if_id_instruction, got.instr);
        chk({tag, ".pc"},     {22'd0, if_id_pc}, {22'd0, got.pc});
        chk({tag, ".pcn"},    {22'd0, if_id_pc_next}, {22'd0, got.pcn});
        chk({tag, ".valid"},  {31'd0, if_id_valid}, {31'd0, got.valid});
        chk({tag, ".halted"}, {31'd0, halted}, {31'd0, got.halted});
        chk({tag, ".addr"},   {22'd0, imem_address}, {22'd0, got.addr});
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = word(i);
        reset = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_pc = '0;

        // 1: reset for two edges, then sequential fetch
        step("rst0", 1, 0, 0, 10'h000, ex(32'h0, 10'd0, 10'd0, 0, 0, 10'd0));
        step("rst1", 1, 0, 0, 10'h000, ex(32'h0, 10'd0, 10'd0, 0, 0, 10'd0));
        step("run0", 0, 0, 0, 10'h000, ex(word(0), 10'd0, 10'd1, 1, 0, 10'd1));
        step("run1", 0, 0, 0, 10'h000, ex(word(1), 10'd1, 10'd2, 1, 0, 10'd2));
        step("run2", 0, 0, 0, 10'h000, ex(word(2), 10'd2, 10'd3, 1, 0, 10'd3));

        // 2: three stalled edges hold everything
        for (int i = 0; i < 3; i++)
            step("stall", 0, 1, 0, 10'h000, ex(word(2), 10'd2, 10'd3, 1, 0, 10'd3));
        step("unstall", 0, 0, 0, 10'h000, ex(word(3), 10'd3, 10'd4, 1, 0, 10'd4));

        // 3: redirect beats stall
        step("redir_st", 0, 1, 1, 10'h200, ex(32'h0, 10'd3, 10'd4, 0, 0, 10'h200));
        step("redir_f",  0, 0, 0, 10'h000, ex(word(10'h200), 10'h200, 10'h201, 1, 0, 10'h201));

        // 4: wrap at the top of the address space
        step("wrap_rd", 0, 0, 1, 10'h3FF, ex(32'h0, 10'h200, 10'h201, 0, 0, 10'h3FF));
        step("wrap_top", 0, 0, 0, 10'h000, ex(word(10'h3FF), 10'h3FF, 10'h000, 1, 0, 10'h000));
        step("wrap_0",   0, 0, 0, 10'h000, ex(word(0), 10'h000, 10'h001, 1, 0, 10'h001));
        for (int a = 1; a < 5; a++)
            step("run_a", 0, 0, 0, 10'h000, ex(word(a), 10'(a), 10'(a + 1), 1, 0, 10'(a + 1)));

        // 5: reset while stalled (and redirecting) at pc=5
        step("st5", 0, 1, 0, 10'h000, ex(word(4), 10'd4, 10'd5, 1, 0, 10'd5));
        step("rst_mid", 1, 1, 1, 10'h155, ex(32'h0, 10'd0, 10'd0, 0, 0, 10'd0));
        mem[4] = 32'hFFFF_FFFF;
        for (int a = 0; a < 4; a++)
            step("rerun", 0, 0, 0, 10'h000, ex(word(a), 10'(a), 10'(a + 1), 1, 0, 10'(a + 1)));

        // 6: halt word at address 4
`ifdef IF_HALT_EN
        step("halt",     0, 0, 0, 10'h000, ex(32'h0, 10'd3, 10'd4, 0, 1, 10'd4));
        step("halt_rd",  0, 0, 1, 10'h100, ex(32'h0, 10'd3, 10'd4, 0, 1, 10'd4));
        step("halt_st",  0, 1, 0, 10'h000, ex(32'h0, 10'd3, 10'd4, 0, 1, 10'd4));
`else
        step("haltw",    0, 0, 0, 10'h000, ex(32'hFFFF_FFFF, 10'd4, 10'd5, 1, 0, 10'd5));
        step("haltw_rd", 0, 0, 1, 10'h100, ex(32'h0, 10'd4, 10'd5, 0, 0, 10'h100));
        step("haltw_f",  0, 0, 0, 10'h000, ex(word(10'h100), 10'h100, 10'h101, 1, 0, 10'h101));
`endif
        step("halt_rst", 1, 0, 0, 10'h000, ex(32'h0, 10'd0, 10'd0, 0, 0, 10'd0));
        step("post_rst", 0, 0, 0, 10'h000, ex(word(0), 10'd0, 10'd1, 1, 0, 10'd1));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
